// File: rtl/instruction_fetch_unit_if.sv
// Shared NOC packet/queue types and the ip_port interface used by instruction_fetch_unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    port_closed = 2'd0,
    port_open   = 2'd1,
    port_busy   = 2'd2
  } prt_stat_e;

  typedef enum logic [1:0] {
    memory_read_request  = 2'd0,
    memory_read_reply    = 2'd1,
    memory_write_request = 2'd2,
    memory_write_ack     = 2'd3
  } pkt_type_e;

  typedef struct packed {
    logic [7:0]   dst_addr;
    logic [3:0]   dst_prt;
    logic [7:0]   src_addr;
    logic [3:0]   src_prt;
    logic [7:0]   id;
    pkt_type_e    pt;
    logic [127:0] dat;
  } noc_packet_t;

  typedef struct packed {
    logic [63:0] inst;
    logic [31:0] addr;
    logic [3:0]  len;
  } queued_instruction;

endpackage

interface ip_port;
  import ifu_pkg::*;

  logic [7:0]  port_address;
  logic [3:0]  port_number;
  prt_stat_e   to_noc_prt_stat;
  logic        tx_submit;
  logic        tx_complete;
  noc_packet_t dat_to_noc;
  logic        rx_recieve;
  logic        rx_complete;
  noc_packet_t dat_from_noc;

  modport client (
    input  port_address, port_number, to_noc_prt_stat, tx_complete,
           rx_recieve, dat_from_noc,
    output tx_submit, dat_to_noc, rx_complete
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetches 16-byte lines over the NOC, splits them into variable-length instructions
// and queues them. Optional IFU_PERF_CNT_EN adds fetch_cnt / flush_cnt counters.
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter int unsigned IQ_DEPTH = 4,
  parameter int unsigned FB_BYTES = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mdfy_pc,
  input  logic [31:0]               new_pc_val,
  output ifu_pkg::queued_instruction iq_oup,
  output logic                      iq_valid,
  input  logic                      iq_pop,
  ip_port.client                    noc_port
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]               fetch_cnt,
  output logic [31:0]               flush_cnt
`endif
);

  localparam int unsigned AW  = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
  localparam int unsigned CW  = $clog2(FB_BYTES + 1);
  localparam int unsigned FBW = FB_BYTES * 8;

  typedef enum logic [1:0] {ISSUE, SUBMIT, WAIT, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       dec_pc_q, dec_pc_d;
  logic [FBW-1:0]    fb_q, fb_d;
  logic [CW-1:0]     fb_cnt_q, fb_cnt_d;
  queued_instruction iq_q [IQ_DEPTH];
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]       iq_cnt_q, iq_cnt_d;
  logic              tx_submit_q;
  noc_packet_t       pkt_q, req_pkt;
  logic              rx_complete_q;

  logic              tx_accept, rx_reply, append, discard;
  logic              iq_full, push_ok, pop_ok;
  logic [3:0]        cur_len;
  logic [63:0]       len_mask;
  queued_instruction push_entry;
  logic [FBW-1:0]    fb_keep;
  logic [CW-1:0]     cnt_keep;

  logic unused_rx_hdr;
  assign unused_rx_hdr = ^{noc_port.dat_from_noc.dst_addr, noc_port.dat_from_noc.dst_prt,
                           noc_port.dat_from_noc.src_addr, noc_port.dat_from_noc.src_prt,
                           noc_port.dat_from_noc.id};

  always_comb begin
    tx_accept = (state_q == SUBMIT) && (noc_port.to_noc_prt_stat == port_open)
                && noc_port.tx_complete;
    rx_reply  = noc_port.rx_recieve && (noc_port.dat_from_noc.pt == memory_read_reply);
    append    = !mdfy_pc && (state_q == WAIT) && rx_reply;
    discard   = !mdfy_pc && (state_q == DRAIN) && rx_reply;

    cur_len   = {1'b0, fb_q[2:0]} + 4'd1;
    len_mask  = 64'hFFFF_FFFF_FFFF_FFFF >> (7'd64 - {cur_len, 3'b000});
    iq_full   = (iq_cnt_q == (AW+1)'(IQ_DEPTH));
    pop_ok    = !mdfy_pc && iq_pop && (iq_cnt_q != '0);
    push_ok   = !mdfy_pc && (fb_cnt_q >= CW'(cur_len)) && (!iq_full || iq_pop);

    push_entry      = '0;
    push_entry.inst = fb_q[63:0] & len_mask;
    push_entry.addr = dec_pc_q;
    push_entry.len  = cur_len;

    // Consume the pushed instruction first, then land a reply right after what is left.
    fb_keep  = push_ok ? (fb_q >> {cur_len, 3'b000}) : fb_q;
    cnt_keep = fb_cnt_q - (push_ok ? CW'(cur_len) : '0);
    fb_d     = fb_keep;
    fb_cnt_d = cnt_keep;
    if (append) begin
      fb_d     = fb_keep | (FBW'(noc_port.dat_from_noc.dat) << {cnt_keep, 3'b000});
      fb_cnt_d = cnt_keep + CW'(16);
    end

    fetch_pc_d = append ? fetch_pc_q + 32'd16 : fetch_pc_q;
    dec_pc_d   = push_ok ? dec_pc_q + 32'(cur_len) : dec_pc_q;
    rd_ptr_d   = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    iq_cnt_d   = iq_cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);

    state_d = state_q;
    unique case (state_q)
      ISSUE:  if ((CW'(FB_BYTES) - fb_cnt_q) >= CW'(16)) state_d = SUBMIT;
      SUBMIT: if (tx_accept) state_d = WAIT;
      WAIT:   if (rx_reply) state_d = ISSUE;
      DRAIN:  if (rx_reply) state_d = ISSUE;
      default: state_d = ISSUE;
    endcase

    // A request already on the wire still owes us a reply, so a flush must drain it.
    if (mdfy_pc) begin
      fb_d       = '0;
      fb_cnt_d   = '0;
      fetch_pc_d = new_pc_val;
      dec_pc_d   = new_pc_val;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      iq_cnt_d   = '0;
      state_d    = (state_q == WAIT || state_q == DRAIN || tx_accept) ? DRAIN : ISSUE;
    end

    req_pkt          = '0;
    req_pkt.dst_addr = 8'd2;
    req_pkt.dst_prt  = 4'd0;
    req_pkt.src_addr = noc_port.port_address;
    req_pkt.src_prt  = noc_port.port_number;
    req_pkt.id       = 8'd1;
    req_pkt.pt       = memory_read_request;
    req_pkt.dat      = {96'd0, fetch_pc_d};
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, flush_cnt_q;
  assign fetch_cnt = fetch_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ISSUE;
      fetch_pc_q    <= '0;
      dec_pc_q      <= '0;
      fb_q          <= '0;
      fb_cnt_q      <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      iq_cnt_q      <= '0;
      tx_submit_q   <= 1'b0;
      pkt_q         <= '0;
      rx_complete_q <= 1'b0;
`ifdef IFU_PERF_CNT_EN
      fetch_cnt_q   <= '0;
      flush_cnt_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      dec_pc_q      <= dec_pc_d;
      fb_q          <= fb_d;
      fb_cnt_q      <= fb_cnt_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      iq_cnt_q      <= iq_cnt_d;
      if (push_ok) iq_q[wr_ptr_q] <= push_entry;
      tx_submit_q   <= (state_d == SUBMIT);
      pkt_q         <= (state_d == SUBMIT) ? req_pkt : '0;
      rx_complete_q <= append || discard;
`ifdef IFU_PERF_CNT_EN
      fetch_cnt_q   <= fetch_cnt_q + 32'(append);
      flush_cnt_q   <= flush_cnt_q + 32'(mdfy_pc);
`endif
    end
  end

  assign iq_valid             = (iq_cnt_q != '0);
  assign iq_oup               = iq_q[rd_ptr_q];
  assign noc_port.tx_submit   = tx_submit_q;
  assign noc_port.dat_to_noc  = pkt_q;
  assign noc_port.rx_complete = rx_complete_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; counter checks compile in with IFU_PERF_CNT_EN.
module tb_instruction_fetch_unit;
  import ifu_pkg::*;

  logic              clk;
  logic              rst;
  logic              mdfy_pc;
  logic [31:0]       new_pc_val;
  queued_instruction iq_oup;
  logic              iq_valid;
  logic              iq_pop;
`ifdef IFU_PERF_CNT_EN
  logic [31:0]       fetch_cnt, flush_cnt;
`endif

  ip_port noc();

  instruction_fetch_unit #(.IQ_DEPTH(4), .FB_BYTES(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .mdfy_pc    (mdfy_pc),
    .new_pc_val (new_pc_val),
    .iq_oup     (iq_oup),
    .iq_valid   (iq_valid),
    .iq_pop     (iq_pop),
    .noc_port   (noc)
`ifdef IFU_PERF_CNT_EN
    ,
    .fetch_cnt  (fetch_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  int nvec;
  int nfail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic noc_packet_t exp_req(input logic [31:0] a);
    noc_packet_t p;
    p          = '0;
    p.dst_addr = 8'd2;
    p.dst_prt  = 4'd0;
    p.src_addr = 8'h07;
    p.src_prt  = 4'h3;
    p.id       = 8'd1;
    p.pt       = memory_read_request;
    p.dat      = {96'd0, a};
    return p;
  endfunction

  function automatic noc_packet_t reply(input logic [127:0] d);
    noc_packet_t p;
    p     = '0;
    p.pt  = memory_read_reply;
    p.dat = d;
    return p;
  endfunction

  task automatic wait_submit(input string tag);
    for (int i = 0; i < 80; i++) begin
      if (noc.tx_submit) break;
      tick();
    end
    chk(tag, 256'(noc.tx_submit), 256'(1'b1));
  endtask

  task automatic chk_head(input string tag, input logic [63:0] inst, input logic [31:0] addr,
                          input logic [3:0] len);
    chk({tag, "_valid"}, 256'(iq_valid), 256'(1'b1));
    chk({tag, "_inst"}, 256'(iq_oup.inst), 256'(inst));
    chk({tag, "_addr"}, 256'(iq_oup.addr), 256'(addr));
    chk({tag, "_len"}, 256'(iq_oup.len), 256'(len));
  endtask

  initial begin
    nvec = 0;
    nfail = 0;
    rst = 1'b1;
    mdfy_pc = 1'b0;
    new_pc_val = '0;
    iq_pop = 1'b0;
    noc.port_address = 8'h07;
    noc.port_number = 4'h3;
    noc.to_noc_prt_stat = port_open;
    noc.tx_complete = 1'b0;
    noc.rx_recieve = 1'b0;
    noc.dat_from_noc = '0;

    tick();
    tick();
    chk("rst_iq_valid", 256'(iq_valid), 256'(1'b0));
    chk("rst_tx_submit", 256'(noc.tx_submit), 256'(1'b0));
    chk("rst_rx_complete", 256'(noc.rx_complete), 256'(1'b0));
    chk("rst_dat_to_noc", 256'(noc.dat_to_noc), 256'(0));
`ifdef IFU_PERF_CNT_EN
    chk("rst_fetch_cnt", 256'(fetch_cnt), 256'(0));
    chk("rst_flush_cnt", 256'(flush_cnt), 256'(0));
`endif
    rst = 1'b0;

    // Pop on an empty queue must be ignored.
    iq_pop = 1'b1;
    tick();
    iq_pop = 1'b0;
    chk("empty_pop_valid", 256'(iq_valid), 256'(1'b0));
    wait_submit("submit0");
    chk("req0_pkt", 256'(noc.dat_to_noc), 256'(exp_req(32'h0)));

    noc.tx_complete = 1'b1;
    tick();
    noc.tx_complete = 1'b0;
    chk("req0_released", 256'(noc.tx_submit), 256'(1'b0));

    noc.dat_from_noc = reply(128'h0000_0000_0000_0000_0000_5544_3322_1105);
    noc.rx_recieve = 1'b1;
    tick();
    chk("rep0_rx_complete", 256'(noc.rx_complete), 256'(1'b1));
    noc.rx_recieve = 1'b0;
    tick();
    chk("rep0_rx_complete_pulse", 256'(noc.rx_complete), 256'(1'b0));
    chk_head("first", 64'h0000_5544_3322_1105, 32'h0, 4'd6);
    chk("req1_pkt", 256'(noc.dat_to_noc), 256'(exp_req(32'h10)));

    // Request held while tx_complete is withheld; queue fills and stalls.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_tx_submit", 256'(noc.tx_submit), 256'(1'b1));
      chk("hold_pkt", 256'(noc.dat_to_noc), 256'(exp_req(32'h10)));
    end
    chk_head("full_head", 64'h0000_5544_3322_1105, 32'h0, 4'd6);

    // Pop at full while a push is pending; also hand off the request.
    iq_pop = 1'b1;
    noc.tx_complete = 1'b1;
    tick();
    noc.tx_complete = 1'b0;
    chk("req1_released", 256'(noc.tx_submit), 256'(1'b0));
    chk_head("pop_full", 64'h0, 32'h6, 4'd1);
    tick();
    chk_head("pop_a", 64'h0, 32'h7, 4'd1);
    tick();
    chk_head("pop_b", 64'h0, 32'h8, 4'd1);
    iq_pop = 1'b0;

    mdfy_pc = 1'b1;
    new_pc_val = 32'h100;
    tick();
    mdfy_pc = 1'b0;
    chk("flush_iq_valid", 256'(iq_valid), 256'(1'b0));
    chk("flush_tx_submit", 256'(noc.tx_submit), 256'(1'b0));

    noc.dat_from_noc = reply(128'h0000_0000_0000_0000_0000_0000_0000_7707);
    noc.rx_recieve = 1'b1;
    tick();
    chk("stale_rx_complete", 256'(noc.rx_complete), 256'(1'b1));
    noc.rx_recieve = 1'b0;
    tick();
    chk("stale_no_append", 256'(iq_valid), 256'(1'b0));
    chk("redir_submit", 256'(noc.tx_submit), 256'(1'b1));
    chk("redir_pkt", 256'(noc.dat_to_noc), 256'(exp_req(32'h100)));

    // Redirect while the request is not yet accepted returns to ISSUE, no drain.
    mdfy_pc = 1'b1;
    new_pc_val = 32'hFFFF_FFF0;
    tick();
    mdfy_pc = 1'b0;
    chk("redir2_drop_submit", 256'(noc.tx_submit), 256'(1'b0));
    tick();
    chk("wrap_req_pkt", 256'(noc.dat_to_noc), 256'(exp_req(32'hFFFF_FFF0)));
    noc.tx_complete = 1'b1;
    tick();
    noc.tx_complete = 1'b0;
    noc.dat_from_noc = reply(128'h0000_0000_0000_0000_0000_0000_0000_AB01);
    noc.rx_recieve = 1'b1;
    tick();
    chk("wrap_rx_complete", 256'(noc.rx_complete), 256'(1'b1));
    noc.rx_recieve = 1'b0;
    tick();
    chk_head("wrap_head", 64'h0000_0000_0000_AB01, 32'hFFFF_FFF0, 4'd2);
    chk("wrap_next_req", 256'(noc.dat_to_noc), 256'(exp_req(32'h0)));

    noc.tx_complete = 1'b1;
    tick();
    noc.tx_complete = 1'b0;
    noc.dat_from_noc = reply(128'h0);
    noc.rx_recieve = 1'b1;
    tick();
    chk("rep3_rx_complete", 256'(noc.rx_complete), 256'(1'b1));
    noc.rx_recieve = 1'b0;
`ifdef IFU_PERF_CNT_EN
    tick();
    chk("fetch_cnt", 256'(fetch_cnt), 256'(3));
    chk("flush_cnt", 256'(flush_cnt), 256'(2));
`endif

    // Reset with a request outstanding: the late reply must be ignored.
    iq_pop = 1'b1;
    wait_submit("submit4");
    iq_pop = 1'b0;
    noc.tx_complete = 1'b1;
    tick();
    noc.tx_complete = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_iq_valid", 256'(iq_valid), 256'(1'b0));
    chk("rst2_dat_to_noc", 256'(noc.dat_to_noc), 256'(0));
`ifdef IFU_PERF_CNT_EN
    chk("rst2_fetch_cnt", 256'(fetch_cnt), 256'(0));
`endif
    noc.dat_from_noc = reply(128'h0000_0000_0000_0000_0000_0000_0000_0003);
    noc.rx_recieve = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("late_rx_complete", 256'(noc.rx_complete), 256'(1'b0));
    end
    noc.rx_recieve = 1'b0;
    chk("late_no_append", 256'(iq_valid), 256'(1'b0));
    chk("post_rst_pkt", 256'(noc.dat_to_noc), 256'(exp_req(32'h0)));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
